// File: rtl/flp_adder_tree_ctrl.sv
// Sequencer for the 10-input floating-point adder tree: banks a stream of elements,
// waits out the tree latency, then holds the captured exp/mant on a valid/ready port.
module flp_adder_tree_ctrl #(
  parameter int N_IN     = 10,
  parameter int DW       = 8,
  parameter int TREE_LAT = 2,
  parameter int EXP_W    = 9,
  parameter int MANT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DW-1:0]        i_in_data,
  input  logic                 i_in_valid,
  input  logic                 i_in_last,
  output logic                 o_in_ready,
  output logic [N_IN*DW-1:0]   o_x_flat,
  input  logic [EXP_W-1:0]     i_tree_exp,
  input  logic [MANT_W-1:0]    i_tree_mant,
  output logic [EXP_W-1:0]     o_sum_exp,
  output logic [MANT_W-1:0]    o_sum_mant,
  output logic [3:0]           o_sum_count,
  output logic                 o_sum_valid,
  input  logic                 i_sum_ready,
  output logic                 o_busy
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CW = (TREE_LAT > 0) ? $clog2(TREE_LAT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DW-1:0]       r_bank [N_IN];
  logic [IW-1:0]       r_idx;
  logic [CW-1:0]       r_cnt;
  logic [EXP_W-1:0]    r_sum_exp;
  logic [MANT_W-1:0]   r_sum_mant;
  logic [3:0]          r_sum_count;
  logic                w_accept;
  logic                w_last;
  logic                w_handshake;
  logic                w_cnt_zero;

  assign w_accept    = o_in_ready & i_in_valid;
  assign w_last      = i_in_last | (r_idx == IW'(N_IN - 1));
  assign w_handshake = o_sum_valid & i_sum_ready;
  assign w_cnt_zero  = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: w_state_next = S_LOAD;
      S_LOAD: if (w_accept && w_last) w_state_next = S_WAIT;
      S_WAIT: if (w_cnt_zero) w_state_next = S_DONE;
      S_DONE: if (w_handshake) w_state_next = S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decode the state register directly, so they are glitch-free and
  // all read 0 while reset is held.
  always_comb begin
    o_in_ready  = (r_state == S_LOAD);
    o_sum_valid = (r_state == S_DONE);
    o_busy      = (r_state == S_WAIT) || (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) r_bank[i] <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_sum_exp   <= '0;
      r_sum_mant  <= '0;
      r_sum_count <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_bank[r_idx] <= i_in_data;
            if (w_last) begin
              // idx parks at 0 so it never walks past the last slot
              r_idx       <= '0;
              r_cnt       <= CW'(TREE_LAT);
              r_sum_count <= 4'(r_idx) + 4'd1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (w_cnt_zero) begin
            r_sum_exp  <= i_tree_exp;
            r_sum_mant <= i_tree_mant;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (w_handshake) begin
            for (int i = 0; i < N_IN; i++) r_bank[i] <= '0;
            r_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_slot
      assign o_x_flat[gi*DW +: DW] = r_bank[gi];
    end
  endgenerate

  assign o_sum_exp   = r_sum_exp;
  assign o_sum_mant  = r_sum_mant;
  assign o_sum_count = r_sum_count;

endmodule

// File: tb/tb_flp_adder_tree_ctrl.sv
// Randomized bench for flp_adder_tree_ctrl with a latency-accurate adder tree model
// (exp = 120 + nonzero inputs, mant = byte sum; garbage while inputs are settling).
module tb_flp_adder_tree_ctrl;
  localparam int N_IN = 10, DW = 8, TREE_LAT = 2, EXP_W = 9, MANT_W = 8;

  logic              clk, rst_n;
  logic [DW-1:0]     in_data;
  logic              in_valid, in_last, in_ready;
  logic [N_IN*DW-1:0] x_flat;
  logic [EXP_W-1:0]  tree_exp, sum_exp;
  logic [MANT_W-1:0] tree_mant, sum_mant;
  logic [3:0]        sum_count;
  logic              sum_valid, sum_ready, busy;

  int errors = 0;
  int checks = 0;

  flp_adder_tree_ctrl #(.N_IN(N_IN), .DW(DW), .TREE_LAT(TREE_LAT), .EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_data(in_data), .i_in_valid(in_valid), .i_in_last(in_last), .o_in_ready(in_ready),
    .o_x_flat(x_flat), .i_tree_exp(tree_exp), .i_tree_mant(tree_mant),
    .o_sum_exp(sum_exp), .o_sum_mant(sum_mant), .o_sum_count(sum_count),
    .o_sum_valid(sum_valid), .i_sum_ready(sum_ready), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder tree model: output valid TREE_LAT edges after x_flat settles.
  logic [N_IN*DW-1:0] tree_st1, tree_st2;
  logic               glitch_on = 1'b0;
  logic [EXP_W-1:0]   glitch_exp = '0;
  logic [MANT_W-1:0]  glitch_mant = '0;
  always @(posedge clk) begin
    tree_st1 <= x_flat;
    tree_st2 <= tree_st1;
  end
  always_comb begin
    int nz;
    int sm;
    nz = 0;
    sm = 0;
    for (int k = 0; k < N_IN; k++) begin
      if (x_flat[k*DW +: DW] != 0) nz++;
      sm += int'(x_flat[k*DW +: DW]);
    end
    if (glitch_on) begin
      tree_exp  = glitch_exp;
      tree_mant = glitch_mant;
    end else if (tree_st1 === x_flat && tree_st2 === x_flat) begin
      tree_exp  = EXP_W'(120 + nz);
      tree_mant = MANT_W'(sm);
    end else begin
      tree_exp  = '1;
      tree_mant = '1;
    end
  end

  logic [7:0]          q[$];
  logic [N_IN*DW-1:0]  seen_x;
  logic [EXP_W-1:0]    seen_exp;
  logic [MANT_W-1:0]   seen_mant;
  logic [3:0]          seen_count;
  int                  seen_lat;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed one vector, check latency and result against the model, then handshake.
  task automatic run_vector(input logic [7:0] elems[$], input bit use_last, input int gap_pct,
                            input int bp, input int hold_val, input string tag);
    int n, i, cyc, nz, sm;
    bit acc;
    logic [N_IN*DW-1:0] exp_x;
    logic [EXP_W-1:0]  e_exp;
    logic [MANT_W-1:0] e_mant;
    n = elems.size();
    exp_x = '0; nz = 0; sm = 0;
    for (int k = 0; k < n; k++) begin
      exp_x[k*DW +: DW] = elems[k];
      if (elems[k] != 0) nz++;
      sm += int'(elems[k]);
    end
    e_exp = EXP_W'(120 + nz);
    e_mant = MANT_W'(sm);
    i = 0; cyc = 0;
    while (i < n && cyc < 400) begin
      in_data  = elems[i];
      in_last  = use_last && (i == n - 1);
      in_valid = ($urandom_range(99) >= gap_pct);
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) i++;
    end
    checks++;
    if (i != n) begin errors++; $display("FAIL %s accept_timeout: accepted %0d required %0d", tag, i, n); end
    if (hold_val >= 0) begin in_valid = 1'b1; in_data = 8'(hold_val); end
    else in_valid = 1'b0;
    in_last = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s post_accept: in_ready=%b busy=%b required 0/1", tag, in_ready, busy);
    end
    cyc = 0;
    while (sum_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    seen_lat = cyc;
    checks++;
    if (cyc != TREE_LAT + 1) begin errors++; $display("FAIL %s latency: got %0d edges required %0d", tag, cyc, TREE_LAT + 1); end
    checks++;
    if (x_flat !== exp_x) begin errors++; $display("FAIL %s x_flat: got %h required %h", tag, x_flat, exp_x); end
    checks++;
    if (sum_count !== 4'(n)) begin errors++; $display("FAIL %s sum_count: got %0d required %0d", tag, sum_count, n); end
    checks++;
    if (sum_exp !== e_exp || sum_mant !== e_mant) begin
      errors++; $display("FAIL %s sum: got exp=%0d mant=%0d required exp=%0d mant=%0d", tag, sum_exp, sum_mant, e_exp, e_mant);
    end
    seen_x = x_flat; seen_exp = sum_exp; seen_mant = sum_mant; seen_count = sum_count;
    sum_ready = 1'b0;
    for (int b = 0; b < bp; b++) begin
      glitch_on = 1'b1;
      glitch_exp = EXP_W'($urandom);
      glitch_mant = MANT_W'($urandom);
      step();
      checks++;
      if (sum_valid !== 1'b1 || in_ready !== 1'b0 || sum_exp !== e_exp || sum_mant !== e_mant || sum_count !== 4'(n)) begin
        errors++;
        $display("FAIL %s backpressure: valid=%b rdy=%b exp=%0d mant=%0d cnt=%0d required 1 0 %0d %0d %0d",
                 tag, sum_valid, in_ready, sum_exp, sum_mant, sum_count, e_exp, e_mant, n);
      end
    end
    glitch_on = 1'b0;
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    checks++;
    if (sum_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || x_flat !== '0) begin
      errors++;
      $display("FAIL %s handshake: valid=%b rdy=%b busy=%b x_flat=%h required 0 1 0 0", tag, sum_valid, in_ready, busy, x_flat);
    end
    $display("vec %s: n=%0d count=%0d exp=%0d mant=%0d lat=%0d", tag, n, seen_count, seen_exp, seen_mant, seen_lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; sum_ready = 1'b0;
    step(); step();
    checks++;
    if (in_ready !== 0 || sum_valid !== 0 || busy !== 0 || x_flat !== '0 || sum_exp !== '0 || sum_mant !== '0 || sum_count !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b valid=%b busy=%b x=%h exp=%0d mant=%0d cnt=%0d required all 0",
               in_ready, sum_valid, busy, x_flat, sum_exp, sum_mant, sum_count);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b required 0", in_ready); end
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b required 1", in_ready); end
    $display("reset done");
  endtask

  task automatic test_full_vector();
    q = {};
    for (int k = 1; k <= 10; k++) q.push_back(8'(k));
    run_vector(q, 1'b1, 0, 0, -1, "full");
    checks++;
    if (seen_x !== 80'h0A090807060504030201 || seen_exp !== 9'd130 || seen_mant !== 8'd55 || seen_count !== 4'd10) begin
      errors++;
      $display("FAIL full_literal: x=%h exp=%0d mant=%0d cnt=%0d required 0A090807060504030201 130 55 10",
               seen_x, seen_exp, seen_mant, seen_count);
    end
  endtask

  task automatic test_partial();
    q = {8'h11, 8'h22, 8'h33};
    run_vector(q, 1'b1, 0, 0, -1, "partial");
    checks++;
    if (seen_x[23:0] !== 24'h332211 || seen_x[79:24] !== '0) begin
      errors++; $display("FAIL partial_slots: got %h required low 332211 rest 0", seen_x);
    end
  endtask

  task automatic test_backpressure();
    q = {8'h5A, 8'h00, 8'hC3, 8'h7E, 8'h01};
    run_vector(q, 1'b1, 0, 5, -1, "backpressure");
  endtask

  task automatic test_implicit_last();
    q = {};
    for (int k = 1; k <= 10; k++) q.push_back(8'(k));
    run_vector(q, 1'b0, 0, 2, 8'h0B, "implicit_a");
    q = {8'h0B, 8'h0C};
    run_vector(q, 1'b1, 0, 0, -1, "implicit_b");
    checks++;
    if (seen_x[15:0] !== 16'h0C0B) begin errors++; $display("FAIL implicit_carry: got %h required 0C0B", seen_x[15:0]); end
  endtask

  task automatic test_gappy();
    q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_vector(q, 1'b1, 50, 0, -1, "gappy");
  endtask

  task automatic test_back_to_back_random();
    int n;
    for (int v = 0; v < 8; v++) begin
      n = $urandom_range(10, 1);
      q = {};
      for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      run_vector(q, (n < 10) ? 1'b1 : 1'($urandom_range(1)), 30, $urandom_range(3), -1, "random");
    end
  endtask

  task automatic test_reset_mid_wait();
    int i;
    bit acc;
    q = {8'h44, 8'h55, 8'h66};
    i = 0;
    for (int c = 0; c < 50 && i < 3; c++) begin
      in_valid = 1'b1; in_data = q[i]; in_last = (i == 2);
      acc = in_ready;
      step();
      if (acc) i++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 0 || sum_valid !== 0 || busy !== 0 || x_flat !== '0) begin
      errors++; $display("FAIL async_reset: rdy=%b valid=%b busy=%b x=%h required 0", in_ready, sum_valid, busy, x_flat);
    end
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_idle_ready: got %b required 0", in_ready); end
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b required 1", in_ready); end
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (sum_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL aborted_emit: valid=%b busy=%b required 0 0", sum_valid, busy);
      end
    end
    $display("reset mid-wait done");
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_partial();
    test_backpressure();
    test_implicit_last();
    test_gappy();
    test_back_to_back_random();
    test_reset_mid_wait();
    test_partial();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/flp_adder_tree_ctrl.md
Name: flp_adder_tree_ctrl

Overview:
- Sequencer in front of the 10-input floating-point adder tree (x1..x10 in, exp/mant out) used by the pseudo-softmax denominator path.
- Collects a stream of 8-bit elements into an input bank and drives the bank onto the tree inputs.
- Waits the tree's fixed latency, then captures the tree's exponent/mantissa into a registered result.
- Presents the result on a valid/ready output, so the tree is shared across successive vectors without source-side timing knowledge.

Parameters:
- N_IN, 10, number of tree input slots (max elements per vector).
- DW, 8, element width.
- TREE_LAT, 2, tree latency: number of clock edges after x_flat changes before tree_exp/tree_mant are valid. 0 means combinational.
- EXP_W, 9, tree exponent width.
- MANT_W, 8, tree mantissa width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DW  element to load.
- in_valid  in  1  in_data valid.
- in_last  in  1  final element of the vector; qualified by in_valid.
- in_ready  out  1  controller accepts an element this cycle.
- x_flat  out  N_IN*DW  registered tree inputs; slot i (x(i+1)) at bits [i*DW +: DW].
- tree_exp  in  EXP_W  adder tree exponent output.
- tree_mant  in  MANT_W  adder tree mantissa output.
- sum_exp  out  EXP_W  captured exponent.
- sum_mant  out  MANT_W  captured mantissa.
- sum_count  out  4  number of real elements in the captured vector (1..N_IN).
- sum_valid  out  1  result valid.
- sum_ready  in  1  result consumer ready.
- busy  out  1  high in WAIT or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - in_ready = 0, sum_valid = 0, busy = 0.
  - x_flat, sum_exp, sum_mant, sum_count, slot index, wait counter all 0.
- States: IDLE, LOAD, WAIT, DONE.
- IDLE: single cycle after reset release, then -> LOAD unconditionally. Guarantees in_ready stays low during and immediately after reset.
- LOAD:
  - in_ready = 1 (registered; high for the whole state).
  - Accept = in_valid & in_ready.
  - On accept: write in_data to slot idx; idx <= idx + 1.
  - Accept with in_last = 1, or accept at idx = N_IN-1 (implicit last): go to WAIT, load wait counter with TREE_LAT, record sum_count = idx + 1.
  - Slots never written in this vector are 0. The bank is cleared on entry to LOAD.
  - in_valid gaps are allowed; the state holds with no change.
- WAIT:
  - in_ready = 0; x_flat held stable.
  - Wait counter decrements each cycle.
  - At the edge where the counter equals 0: capture tree_exp -> sum_exp and tree_mant -> sum_mant, then go to DONE.
  - Net latency: sum_valid rises TREE_LAT+1 edges after the edge that accepted the last element.
- DONE:
  - sum_valid = 1; sum_exp, sum_mant and sum_count held stable; later changes on tree_exp/tree_mant are ignored.
  - On sum_valid & sum_ready: sum_valid <= 0, clear bank, idx <= 0, go to LOAD (in_ready high on the next cycle).
- busy = (state == WAIT) | (state == DONE).
- An element offered while in_ready = 0 is not consumed; the source must hold it (standard valid/ready).
- Reset asserted mid-operation (any state): all registers return to reset values immediately. A partially loaded vector or pending result is discarded, and nothing is emitted for it.
- idx never exceeds N_IN-1. An element beyond N_IN without in_last starts the next vector.

Test Plan:
- Full vector, TREE_LAT=2, tree model returns exp=9'd130, mant=8'd55 when stable; feed 8'h01..8'h0A back-to-back, last on 8'h0A -> x_flat = 80'h0A090807060504030201; sum_valid rises exactly 3 edges after the 10th accept; sum_exp=130, sum_mant=55, sum_count=10; in_ready low from the 10th accept until 1 cycle after the sum handshake.
- Partial vector: 8'h11, 8'h22, 8'h33 with in_last on 8'h33 -> slots x4..x10 = 0, x_flat[23:0] = 24'h332211, sum_count=3.
- Backpressure: hold sum_ready=0 for 5 cycles in DONE and change tree_exp/tree_mant -> sum_exp/sum_mant/sum_count unchanged, sum_valid held, in_ready=0; release -> one handshake, then LOAD.
- Implicit last: 12 elements 8'h01..8'h0C with no in_last -> first vector holds 01..0A with sum_count=10; 8'h0B is held by the source and loaded into slot x1 of the next vector after the result handshake.
- Gappy input: in_valid toggling 1/0 across a 4-element vector -> only valid beats are written, in order to x1..x4.
- Reset mid-WAIT: assert rst_n=0 two cycles after the last accept -> in_ready, sum_valid, busy and x_flat go to 0 immediately; after release, in_ready=0 for the IDLE cycle, then 1; no sum_valid is emitted for the aborted vector.
